// File: rtl/fir_pkg.sv
// Shared FIR definitions: opcode encoding, well-known register indices and widths.
// Imported by both the control unit and the datapath.
package fir_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int IDX_W          = 4;

  localparam logic [IDX_W-1:0] REG_OUT    = 4'd0;
  localparam logic [IDX_W-1:0] REG_SAMPLE = 4'd5;
  localparam logic [IDX_W-1:0] REG_COEF0  = 4'd7;
  localparam logic [IDX_W-1:0] REG_COEF1  = 4'd8;
  localparam logic [IDX_W-1:0] REG_COEF2  = 4'd9;
  localparam logic [IDX_W-1:0] REG_COEF3  = 4'd10;

  // Encoding 3'd7 is reserved and behaves as NOP.
  typedef enum logic [2:0] {
    NOP   = 3'd0,
    COPY  = 3'd1,
    LOAD1 = 3'd2,
    LOAD2 = 3'd3,
    ADD   = 3'd4,
    SUB   = 3'd5,
    MUL   = 3'd6
  } op_t;

endpackage

// File: rtl/fir_reg_file.sv
// Working register file: flop array with two combinational read ports and one
// write port; reg0 is brought out directly as the output register.
module fir_reg_file
  import fir_pkg::*;
#(
  parameter int REG_W    = 17,
  parameter int NUM_REGS = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             w_en,
  input  logic [IDX_W-1:0] w_sel,
  input  logic [REG_W-1:0] w_data,
  input  logic [IDX_W-1:0] r1_sel,
  input  logic [IDX_W-1:0] r2_sel,
  output logic [REG_W-1:0] r1_data,
  output logic [REG_W-1:0] r2_data,
  output logic [REG_W-1:0] reg0_data
);

  logic [NUM_REGS-1:0][REG_W-1:0] regs_q;
  logic [NUM_REGS-1:0][REG_W-1:0] regs_d;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign regs_d[gi] = (w_en && (w_sel == IDX_W'(gi))) ? w_data : regs_q[gi];
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads come straight from the flops, so a same-cycle write is not visible.
  assign r1_data   = regs_q[r1_sel];
  assign r2_data   = regs_q[r2_sel];
  assign reg0_data = regs_q[0];

endmodule

// File: rtl/fir_datapath.sv
// FIR execution datapath: opcode decode, signed ALU, overflow flag and the
// working register file; reg0 drives the bus-side output word.
module fir_datapath
  import fir_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [2:0]        op,
  input  logic [IDX_W-1:0]  src1,
  input  logic [IDX_W-1:0]  src2,
  input  logic [IDX_W-1:0]  dest,
  input  logic [DATA_W-1:0] ext_data1,
  input  logic [DATA_W-1:0] ext_data2,
  output logic [DATA_W:0]   outreg_data,
  output logic              overflow
);

  localparam int REG_W = DATA_W + 1;
  localparam int MSB   = REG_W - 1;

  logic [REG_W-1:0]   a_val;
  logic [REG_W-1:0]   b_val;
  logic [REG_W-1:0]   sum_val;
  logic [REG_W-1:0]   diff_val;
  logic [2*REG_W-1:0] a_ext;
  logic [2*REG_W-1:0] b_ext;
  logic [2*REG_W-1:0] prod_val;
  logic [REG_W:0]     prod_hi;
  logic               w_en;
  logic [REG_W-1:0]   w_data;
  logic               ovf_q;
  logic               ovf_d;
  op_t                op_dec;

  fir_reg_file #(
    .REG_W    (REG_W),
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk       (clk),
    .n_reset   (n_reset),
    .w_en      (w_en),
    .w_sel     (dest),
    .w_data    (w_data),
    .r1_sel    (src1),
    .r2_sel    (src2),
    .r1_data   (a_val),
    .r2_data   (b_val),
    .reg0_data (outreg_data)
  );

  assign op_dec   = op_t'(op);
  assign sum_val  = a_val + b_val;
  assign diff_val = a_val - b_val;

  // Sign-extended operands make the low 2*REG_W bits of the unsigned product
  // equal to the exact signed product.
  assign a_ext    = {{REG_W{a_val[MSB]}}, a_val};
  assign b_ext    = {{REG_W{b_val[MSB]}}, b_val};
  assign prod_val = a_ext * b_ext;
  assign prod_hi  = prod_val[2*REG_W-1:MSB];

  always_comb begin
    w_en   = 1'b0;
    w_data = a_val;
    ovf_d  = ovf_q;
    case (op_dec)
      COPY: begin
        w_en   = 1'b1;
        w_data = a_val;
      end
      LOAD1: begin
        w_en   = 1'b1;
        w_data = {1'b0, ext_data1};
      end
      LOAD2: begin
        w_en   = 1'b1;
        w_data = {1'b0, ext_data2};
      end
      ADD: begin
        w_en   = 1'b1;
        w_data = sum_val;
        ovf_d  = (a_val[MSB] == b_val[MSB]) && (sum_val[MSB] != a_val[MSB]);
      end
      SUB: begin
        w_en   = 1'b1;
        w_data = diff_val;
        ovf_d  = (a_val[MSB] != b_val[MSB]) && (diff_val[MSB] != a_val[MSB]);
      end
      MUL: begin
        w_en   = 1'b1;
        w_data = prod_val[REG_W-1:0];
        ovf_d  = !((&prod_hi) || !(|prod_hi));
      end
      default: begin
        w_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_fir_datapath.sv
// Directed bench for fir_datapath; registers other than reg0 are observed by
// copying them into reg0 and reading outreg_data.
module tb_fir_datapath;
  import fir_pkg::*;

  logic        clk;
  logic        n_reset;
  logic [2:0]  op;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic [3:0]  dest;
  logic [15:0] ext_data1;
  logic [15:0] ext_data2;
  logic [16:0] outreg_data;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  fir_datapath #(
    .DATA_W   (16),
    .NUM_REGS (16)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .op          (op),
    .src1        (src1),
    .src2        (src2),
    .dest        (dest),
    .ext_data1   (ext_data1),
    .ext_data2   (ext_data2),
    .outreg_data (outreg_data),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Present one op for one cycle, then sample just after the edge.
  task automatic do_op(input logic [2:0] o, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] d, input logic [15:0] e1, input logic [15:0] e2);
    @(negedge clk);
    op = o; src1 = s1; src2 = s2; dest = d; ext_data1 = e1; ext_data2 = e2;
    @(posedge clk);
    #1;
    op = 3'(NOP);
  endtask

  task automatic load1(input logic [3:0] d, input logic [15:0] v);
    do_op(3'(LOAD1), 4'd0, 4'd0, d, v, 16'h0000);
  endtask

  task automatic read_reg(input logic [3:0] r);
    do_op(3'(COPY), r, 4'd0, 4'd0, 16'h0000, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset = 1'b0; op = 3'(NOP); src1 = '0; src2 = '0; dest = '0;
    ext_data1 = '0; ext_data2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", outreg_data, 17'h00000);
    chk("reset_ovf", {16'h0, overflow}, 17'h0);
    @(negedge clk);
    n_reset = 1'b1;

    // 1. Reset landing in the middle of a write
    load1(4'd3, 16'h00AA);
    load1(4'd0, 16'h1111);
    chk("pre_out", outreg_data, 17'h01111);
    load1(4'd1, 16'hFFFF);
    do_op(3'(ADD), 4'd1, 4'd1, 4'd2, 16'h0, 16'h0);
    chk("pre_ovf", {16'h0, overflow}, 17'h1);
    @(negedge clk);
    op = 3'(LOAD1); dest = 4'd3; ext_data1 = 16'hBEEF;
    #2;
    n_reset = 1'b0;
    #1;
    chk("async_out", outreg_data, 17'h00000);
    chk("async_ovf", {16'h0, overflow}, 17'h0);
    @(posedge clk);
    #1;
    chk("held_out", outreg_data, 17'h00000);
    @(negedge clk);
    op = 3'(NOP);
    n_reset = 1'b1;
    read_reg(4'd3);
    chk("reg3_after_rst", outreg_data, 17'h00000);
    read_reg(4'd1);
    chk("reg1_after_rst", outreg_data, 17'h00000);

    // 2. Loads
    load1(4'd5, 16'h1234);
    do_op(3'(LOAD2), 4'd0, 4'd0, 4'd7, 16'h5555, 16'hFFFF);
    chk("load_ovf", {16'h0, overflow}, 17'h0);
    read_reg(4'd5);
    chk("reg5", outreg_data, 17'h01234);
    read_reg(4'd7);
    chk("reg7", outreg_data, 17'h0FFFF);

    // 3. ADD with and without overflow
    load1(4'd1, 16'hFFFF);
    load1(4'd2, 16'h0001);
    do_op(3'(ADD), 4'd1, 4'd2, 4'd0, 16'h0, 16'h0);
    chk("add_ovf_out", outreg_data, 17'h10000);
    chk("add_ovf_flag", {16'h0, overflow}, 17'h1);
    load1(4'd1, 16'h0001);
    do_op(3'(ADD), 4'd1, 4'd1, 4'd0, 16'h0, 16'h0);
    chk("add_out", outreg_data, 17'h00002);
    chk("add_flag", {16'h0, overflow}, 17'h0);

    // 4. SUB and MUL signs
    load1(4'd1, 16'h0005);
    load1(4'd2, 16'h0007);
    do_op(3'(SUB), 4'd1, 4'd2, 4'd0, 16'h0, 16'h0);
    chk("sub_out", outreg_data, 17'h1FFFE);
    chk("sub_flag", {16'h0, overflow}, 17'h0);
    do_op(3'(COPY), 4'd0, 4'd0, 4'd8, 16'h0, 16'h0);
    load1(4'd9, 16'h0003);
    do_op(3'(MUL), 4'd8, 4'd9, 4'd0, 16'h0, 16'h0);
    chk("mul_neg_out", outreg_data, 17'h1FFFA);
    chk("mul_neg_flag", {16'h0, overflow}, 17'h0);
    load1(4'd1, 16'h0100);
    load1(4'd2, 16'h0100);
    do_op(3'(MUL), 4'd1, 4'd2, 4'd0, 16'h0, 16'h0);
    chk("mul_ovf_out", outreg_data, 17'h10000);
    chk("mul_ovf_flag", {16'h0, overflow}, 17'h1);
    do_op(3'(ADD), 4'd9, 4'd9, 4'd11, 16'h0, 16'h0);
    chk("clear_flag", {16'h0, overflow}, 17'h0);
    do_op(3'(COPY), 4'd0, 4'd0, 4'd6, 16'h0, 16'h0);
    do_op(3'(SUB), 4'd6, 4'd2, 4'd0, 16'h0, 16'h0);
    chk("sub_ovf_out", outreg_data, 17'h0FF00);
    chk("sub_ovf_flag", {16'h0, overflow}, 17'h1);

    // 5. Read-during-write uses the old value; new value next cycle
    load1(4'd4, 16'h0009);
    do_op(3'(COPY), 4'd4, 4'd0, 4'd4, 16'h0, 16'h0);
    do_op(3'(ADD), 4'd4, 4'd4, 4'd4, 16'h0, 16'h0);
    do_op(3'(ADD), 4'd4, 4'd4, 4'd0, 16'h0, 16'h0);
    chk("rdw_chain", outreg_data, 17'h00024);
    do_op(3'(ADD), 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
    chk("rdw_reg0", outreg_data, 17'h00048);

    // 6. NOP / reserved op hold state
    load1(4'd1, 16'hFFFF);
    do_op(3'(ADD), 4'd1, 4'd1, 4'd2, 16'h0, 16'h0);
    load1(4'd0, 16'h0777);
    chk("ld_keeps_ovf", {16'h0, overflow}, 17'h1);
    do_op(3'(NOP), 4'd1, 4'd1, 4'd0, 16'h1111, 16'h2222);
    chk("nop_out", outreg_data, 17'h00777);
    chk("nop_ovf", {16'h0, overflow}, 17'h1);
    do_op(3'd7, 4'd1, 4'd1, 4'd0, 16'h3333, 16'h4444);
    chk("op7_out", outreg_data, 17'h00777);
    chk("op7_ovf", {16'h0, overflow}, 17'h1);
    do_op(3'(LOAD2), 4'd0, 4'd0, 4'd12, 16'h0, 16'h0ABC);
    chk("ld2_ovf", {16'h0, overflow}, 17'h1);
    read_reg(4'd12);
    chk("copy_out", outreg_data, 17'h00ABC);
    chk("copy_ovf", {16'h0, overflow}, 17'h1);
    read_reg(4'd2);
    chk("reg2_kept", outreg_data, 17'h1FFFE);
    read_reg(4'd5);
    chk("reg5_kept", outreg_data, 17'h01234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
